// File: rtl/prbs8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs8_pkg
// Description : Shared definitions for the 8-bit Galois LFSR stream
//               (x^8+x^6+x^5+x^4+1): checker state encoding, tap mask and
//               the next-word function used by both generator and checker.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs8_pkg;

    // Checker state encoding; value 3 is unused and recovers to HUNT.
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Bits that receive s7 on each step (n4, n5, n6).
    localparam logic [7:0] TAP_MASK  = 8'h70;

    // One LFSR step: rotate left by one, then fold s7 into the tap bits.
    // Rotation gives n0=s7 and n(i)=s(i-1); the mask adds s7 to n4..n6.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        lfsr8_next = {s[6:0], s[7]} ^ (s[7] ? TAP_MASK : 8'h00);
    endfunction

endpackage : prbs8_pkg
`default_nettype wire

// File: rtl/prbs8_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs8_checker
// Description : Self-synchronising receive checker for the 8-bit LFSR
//               stream. Seeds its predictor from incoming data, confirms
//               lock over LOCK_CNT consecutive matches, then free-runs the
//               predictor and counts mismatching words until UNLOCK_CNT
//               consecutive misses send it back to HUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,   // 1..15
    parameter int unsigned UNLOCK_CNT = 3,   // 1..15
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk_25M,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam logic [3:0]       LOCK_CNT_C   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_CNT_C = 4'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX      = '1;

    // Registered state
    logic [1:0]       state_q,     state_d;
    logic [7:0]       expected_q,  expected_d;
    logic [3:0]       match_q,     match_d;
    logic [3:0]       miss_q,      miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_flag_q,  err_flag_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // Combinational decode of the current word
    logic       word_match;
    logic       word_zero;
    logic       word_err;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;
    logic       lock_hit;
    logic       unlock_hit;

    // Compare against the registered prediction; the counters are bounded
    // by LOCK_CNT/UNLOCK_CNT (<=15) so the 4-bit increments never wrap.
    assign word_match = (din == expected_q);
    assign word_zero  = (din == 8'h00);
    assign match_inc  = match_q + 4'd1;
    assign miss_inc   = miss_q + 4'd1;
    assign lock_hit   = (match_inc >= LOCK_CNT_C);
    assign unlock_hit = (miss_inc >= UNLOCK_CNT_C);
    assign word_err   = din_valid && (state_q == ST_LOCKED) && !word_match;

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            expected_q  <= 8'h00;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic; idle (invalid) cycles hold the state
    always_comb begin
        state_d = state_q;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Zero is the LFSR lock-up word: never seed from it.
                    if (!word_zero) begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (word_match) begin
                        if (lock_hit) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (word_zero) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (!word_match && unlock_hit) begin
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Predictor and lock/unlock run-length counters
    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        miss_d     = miss_q;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (!word_zero) begin
                        expected_d = lfsr8_next(din);
                        match_d    = 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (word_match) begin
                        expected_d = lfsr8_next(din);
                        match_d    = match_inc;
                        if (lock_hit) begin
                            miss_d = 4'd0;
                        end
                    end else if (!word_zero) begin
                        // Reseed immediately from the offending word.
                        expected_d = lfsr8_next(din);
                        match_d    = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // Free-run from the prediction so a single corrupted
                    // word is counted once, not twice.
                    expected_d = lfsr8_next(expected_q);
                    miss_d     = word_match ? 4'd0 : miss_inc;
                end
                default: begin
                    expected_d = expected_q;
                end
            endcase
        end
    end

    // Error outputs: pulse per bad locked word, sticky flag, saturating count
    always_comb begin
        err_pulse_d = word_err;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        if (clear_err) begin
            // Clear wins; this cycle's error is discarded (pulse still fires).
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end else if (word_err) begin
            err_flag_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign state     = state_q;
    assign err_pulse = err_pulse_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;

endmodule : prbs8_checker
`default_nettype wire

// File: tb/tb_prbs8_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs8_checker
// Description : Self-checking bench for prbs8_checker. Two instances share
//               the stimulus: the default configuration and a small one
//               (LOCK_CNT=1, UNLOCK_CNT=15, ERR_W=3) that exercises fast
//               lock and counter saturation. A behavioural model computes
//               the LFSR as multiplication by x modulo the polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs8_checker;

    logic       clk_25M = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       clear_err;

    logic        locked_a, err_pulse_a, err_flag_a;
    logic [15:0] err_count_a;
    logic [1:0]  state_a;
    logic        locked_s, err_pulse_s, err_flag_s;
    logic [2:0]  err_count_s;
    logic [1:0]  state_s;

    always #20 clk_25M = ~clk_25M;

    prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut (
        .clk_25M(clk_25M), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clear_err(clear_err), .locked(locked_a), .err_pulse(err_pulse_a),
        .err_flag(err_flag_a), .err_count(err_count_a), .state(state_a)
    );

    prbs8_checker #(.LOCK_CNT(1), .UNLOCK_CNT(15), .ERR_W(3)) dut_s (
        .clk_25M(clk_25M), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clear_err(clear_err), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_flag(err_flag_s), .err_count(err_count_s), .state(state_s)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, one slot per instance
    int p_lock [2] = '{4, 1};
    int p_unl  [2] = '{3, 15};
    int p_max  [2] = '{65535, 7};
    int m_state[2];
    int m_exp  [2];
    int m_match[2];
    int m_miss [2];
    int m_pulse[2];
    int m_flag [2];
    int m_cnt  [2];

    int gen;   // bench's own copy of the transmitted sequence

    // Next LFSR word: multiply by x in GF(2)[x] / (x^8+x^6+x^5+x^4+1).
    function automatic int nx(input int s);
        int v;
        v = s << 1;
        if ((v & 256) != 0) v = v ^ 'h171;
        return v & 255;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_exp[k] = 0; m_match[k] = 0; m_miss[k] = 0;
            m_pulse[k] = 0; m_flag[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_update(input int k, input int d, input bit v, input bit c);
        bit err;
        err = 0;
        m_pulse[k] = 0;
        if (v) begin
            if (m_state[k] == 0) begin
                if (d != 0) begin
                    m_exp[k] = nx(d); m_match[k] = 1; m_state[k] = 1;
                end
            end else if (m_state[k] == 1) begin
                if (d == m_exp[k]) begin
                    m_exp[k] = nx(d);
                    m_match[k]++;
                    if (m_match[k] >= p_lock[k]) begin
                        m_state[k] = 2; m_miss[k] = 0;
                    end
                end else if (d != 0) begin
                    m_exp[k] = nx(d); m_match[k] = 1;
                end else begin
                    m_state[k] = 0;
                end
            end else begin
                if (d == m_exp[k]) begin
                    m_miss[k] = 0;
                end else begin
                    err = 1;
                    m_pulse[k] = 1;
                    m_miss[k]++;
                    if (m_miss[k] >= p_unl[k]) m_state[k] = 0;
                end
                m_exp[k] = nx(m_exp[k]);
            end
        end
        if (c) begin
            m_cnt[k] = 0; m_flag[k] = 0;
        end else if (err) begin
            m_flag[k] = 1;
            if (m_cnt[k] < p_max[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_all();
        check("a_state",  state_a,     m_state[0]);
        check("a_locked", locked_a,    (m_state[0] == 2) ? 1 : 0);
        check("a_pulse",  err_pulse_a, m_pulse[0]);
        check("a_flag",   err_flag_a,  m_flag[0]);
        check("a_count",  err_count_a, m_cnt[0]);
        check("s_state",  state_s,     m_state[1]);
        check("s_locked", locked_s,    (m_state[1] == 2) ? 1 : 0);
        check("s_pulse",  err_pulse_s, m_pulse[1]);
        check("s_flag",   err_flag_s,  m_flag[1]);
        check("s_count",  err_count_s, m_cnt[1]);
    endtask

    // One clock: drive, let the edge happen, update model, sample #1 later.
    task automatic step(input int d, input bit v, input bit c);
        din       = d[7:0];
        din_valid = v;
        clear_err = c;
        @(posedge clk_25M);
        model_update(0, d, v, c);
        model_update(1, d, v, c);
        #1;
        check_all();
    endtask

    task automatic send_good();
        step(gen, 1'b1, 1'b0);
        gen = nx(gen);
    endtask

    task automatic send_bad(input int mask);
        step(gen ^ mask, 1'b1, 1'b0);
        gen = nx(gen);
    endtask

    initial begin
        int r;
        rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; clear_err = 1'b0;
        model_reset();
        #50;
        check_all();
        check("reset_state", state_a, 0);
        @(negedge clk_25M);
        rst_n = 1'b1;

        // Stuck-low line never seeds
        for (int i = 0; i < 20; i++) step(0, 1'b1, 1'b0);
        check("zero_state",  state_a,     0);
        check("zero_count",  err_count_a, 0);

        // Clean lock on the documented chain
        gen = 'hFF;
        send_good(); send_good(); send_good();
        check("pre_lock", locked_a, 0);
        send_good();
        check("clean_locked", locked_a, 1);
        check("clean_state",  state_a,  2);
        for (int i = 0; i < 5; i++) send_good();
        check("clean_count", err_count_a, 0);

        // Single corrupted word
        send_bad('h01);
        check("single_pulse", err_pulse_a, 1);
        check("single_count", err_count_a, 1);
        check("single_flag",  err_flag_a,  1);
        send_good();
        check("single_pulse_off", err_pulse_a, 0);
        check("single_locked",    locked_a,    1);
        for (int i = 0; i < 3; i++) send_good();

        // Loss of sync after three consecutive bad words
        step(0, 1'b0, 1'b1);
        check("clear_idle", err_count_a, 0);
        for (int i = 0; i < 3; i++) send_bad('h55);
        check("los_count",  err_count_a, 3);
        check("los_state",  state_a,     0);
        check("los_locked", locked_a,    0);
        gen = $urandom_range(1, 255);
        for (int i = 0; i < 4; i++) send_good();
        check("relock", locked_a, 1);

        // Idle gaps inside a locked stream
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) step($urandom_range(0, 255), 1'b0, 1'b0);
            else send_good();
        end
        check("gap_locked", locked_a,    1);
        check("gap_count",  err_count_a, 3);

        // Clear coincident with an error
        step(gen ^ 'h80, 1'b1, 1'b1);
        gen = nx(gen);
        check("clr_pulse", err_pulse_a, 1);
        check("clr_count", err_count_a, 0);
        check("clr_flag",  err_flag_a,  0);

        // Asynchronous reset between edges while locked with errors logged
        send_bad('h02);
        #7;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_locked", locked_a, 0);
        @(negedge clk_25M);
        rst_n = 1'b1;

        // Saturation of the 3-bit counter in the small instance
        gen = $urandom_range(1, 255);
        for (int i = 0; i < 4; i++) send_good();
        for (int i = 0; i < 9; i++) send_bad(1 << (i % 8));
        check("sat_count",  err_count_s, 7);
        check("sat_locked", locked_s,    1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit c;
            c = ($urandom_range(0, 99) < 3);
            r = $urandom_range(0, 99);
            if (r < 10) begin
                step($urandom_range(0, 255), 1'b0, c);
            end else if (r < 15) begin
                step(0, 1'b1, c);
            end else if (r < 25) begin
                step(gen ^ $urandom_range(1, 255), 1'b1, c);
                gen = nx(gen);
            end else if (r < 28) begin
                gen = $urandom_range(1, 255);
                step(gen, 1'b1, c);
                gen = nx(gen);
            end else begin
                step(gen, 1'b1, c);
                gen = nx(gen);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prbs8_checker
`default_nettype wire
